text_console_writer: RTL and testbench

- Write side of the character text display.
- Accepts a byte stream (ASCII plus a few control codes) over a valid/ready handshake and maintains a cursor.
- Writes character codes into the dual-port character RAM at address row*CHAR_PER_LINE + col; the VGA text renderer reads the other port.
- Handles line wrap, newline, carriage return, backspace, screen clear, and clearing of each newly entered line.

---
 rtl/text_console_writer_pkg.sv | 34 +++
 rtl/text_console_writer_if.sv | 33 +++
 rtl/text_console_writer.sv | 174 +++++++++++++++++
 tb/tb_text_console_writer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/text_console_writer_pkg.sv
// Shared definitions for the character text display (writer and renderer).
// Holds screen geometry defaults, the blank cell code, control codes,
// the printable range and the writer state encoding.
package text_pkg;

  // Screen geometry; the renderer must use the same values.
  localparam int CHAR_PER_LINE = 62;
  localparam int NUM_ROWS      = 46;
  localparam int ADDR_WIDTH    = 12;

  // Cell code the renderer draws as an empty cell.
  localparam logic [7:0] BLANK_CHAR = 8'h00;

  // Control codes understood by the writer.
  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  // Printable ASCII range, inclusive.
  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CLEAR_LINE = 2'd1,
    ST_CLEAR_ALL  = 2'd2
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_MIN) && (c <= PRINT_MAX);
  endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Byte-stream input and character-RAM write port of the console writer.
// master: character source (drives char_in/char_valid, observes the rest).
// slave : the writer (drives char_ready and the wr_* RAM write strobe bus).
interface text_console_writer_if #(
  parameter int ADDR_WIDTH = text_pkg::ADDR_WIDTH
);

  logic [7:0]            char_in;
  logic                  char_valid;
  logic                  char_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_data;

  modport master (
    output char_in,
    output char_valid,
    input  char_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  char_in,
    input  char_valid,
    output char_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/text_console_writer.sv
// Write side of the text console: turns a byte stream into character RAM
// writes at row*CHAR_PER_LINE+col, handling wrap, LF, CR, BS and FF.
// Ports: clk, rst (sync, active high), bus (slave: char stream in, RAM
// write out), cursor_col, cursor_row, busy. All outputs registered; a
// write appears one cycle after acceptance; char_ready is low while clearing.
module text_console_writer #(
  parameter int         CHAR_PER_LINE = text_pkg::CHAR_PER_LINE,
  parameter int         NUM_ROWS      = text_pkg::NUM_ROWS,
  parameter int         ADDR_WIDTH    = text_pkg::ADDR_WIDTH,
  parameter logic [7:0] BLANK_CHAR    = text_pkg::BLANK_CHAR
) (
  input  logic                 clk,
  input  logic                 rst,
  text_console_writer_if.slave bus,
  output logic [6:0]           cursor_col,
  output logic [5:0]           cursor_row,
  output logic                 busy
);

  import text_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_CELL  = ADDR_WIDTH'(CHAR_PER_LINE * NUM_ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_LEN   = ADDR_WIDTH'(CHAR_PER_LINE);
  localparam logic [ADDR_WIDTH-1:0] LAST_CNT_L = ADDR_WIDTH'(CHAR_PER_LINE - 1);
  localparam logic [6:0]            LAST_COL   = 7'(CHAR_PER_LINE - 1);
  localparam logic [5:0]            LAST_ROW   = 6'(NUM_ROWS - 1);

  state_t                state_q;
  logic                  char_ready_q;
  logic                  busy_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [7:0]            wr_data_q;
  logic [6:0]            col_q;
  logic [5:0]            row_q;
  logic [ADDR_WIDTH-1:0] row_base_q;   // always row_q*CHAR_PER_LINE
  logic [ADDR_WIDTH-1:0] cnt_q;        // clear sweep counter (line or screen)

  logic                  accept_d;
  logic                  printable_d;
  logic                  advance_d;
  logic [ADDR_WIDTH-1:0] cell_addr_d;
  logic [ADDR_WIDTH-1:0] clr_addr_d;
  logic [5:0]            row_d;
  logic [ADDR_WIDTH-1:0] row_base_d;

  always_comb begin
    accept_d    = bus.char_valid & char_ready_q;
    printable_d = is_printable(bus.char_in);
    // A printable in the last column and LF both move to the next row.
    advance_d   = (printable_d && (col_q == LAST_COL)) || (bus.char_in == CC_LF);
    cell_addr_d = row_base_q + ADDR_WIDTH'(col_q);
    clr_addr_d  = row_base_q + cnt_q;
    // Row base tracks the row incrementally; the bottom row wraps to the top.
    if (row_q == LAST_ROW) begin
      row_d      = '0;
      row_base_d = '0;
    end else begin
      row_d      = row_q + 6'd1;
      row_base_d = row_base_q + LINE_LEN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLEAR_ALL;
      char_ready_q <= 1'b0;
      busy_q       <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= BLANK_CHAR;
      col_q        <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      cnt_q        <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        ST_CLEAR_ALL: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= cnt_q;
          wr_data_q <= BLANK_CHAR;
          if (cnt_q == LAST_CELL) begin
            cnt_q        <= '0;
            state_q      <= ST_IDLE;
            char_ready_q <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_CLEAR_LINE: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= clr_addr_d;
          wr_data_q <= BLANK_CHAR;
          if (cnt_q == LAST_CNT_L) begin
            cnt_q        <= '0;
            state_q      <= ST_IDLE;
            char_ready_q <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_IDLE: begin
          if (accept_d) begin
            // Character write uses the pre-advance row base, so a wrapping
            // character still lands on the row it was typed on.
            if (printable_d) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= cell_addr_d;
              wr_data_q <= bus.char_in;
              col_q     <= (col_q == LAST_COL) ? 7'd0 : col_q + 7'd1;
            end else begin
              case (bus.char_in)
                CC_LF: col_q <= '0;
                CC_CR: col_q <= '0;
                CC_BS: begin
                  if (col_q != 7'd0) begin
                    col_q     <= col_q - 7'd1;
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= cell_addr_d - ADDR_WIDTH'(1);
                    wr_data_q <= BLANK_CHAR;
                  end
                end
                CC_FF: begin
                  col_q        <= '0;
                  row_q        <= '0;
                  row_base_q   <= '0;
                  cnt_q        <= '0;
                  state_q      <= ST_CLEAR_ALL;
                  char_ready_q <= 1'b0;
                  busy_q       <= 1'b1;
                end
                default: ;  // unsupported codes are consumed silently
              endcase
            end

            if (advance_d) begin
              row_q        <= row_d;
              row_base_q   <= row_base_d;
              cnt_q        <= '0;
              state_q      <= ST_CLEAR_LINE;
              char_ready_q <= 1'b0;
              busy_q       <= 1'b1;
            end
          end
        end

        default: begin
          // Unreachable encoding: recover by repainting the whole screen.
          state_q      <= ST_CLEAR_ALL;
          cnt_q        <= '0;
          col_q        <= '0;
          row_q        <= '0;
          row_base_q   <= '0;
          char_ready_q <= 1'b0;
          busy_q       <= 1'b1;
        end
      endcase
    end
  end

  assign bus.char_ready = char_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign cursor_col     = col_q;
  assign cursor_row     = row_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: reset sweep, printable burst,
// line wrap, bottom wrap, backspace, dropped codes, form feed, reset mid-clear.
module tb_text_console_writer;

  logic       clk;
  logic       rst;
  logic [6:0] cursor_col;
  logic [5:0] cursor_row;
  logic       busy;

  int checks = 0;
  int errors = 0;

  text_console_writer_if #(.ADDR_WIDTH(12)) bus ();

  text_console_writer dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for char_ready, then present one character for one cycle.
  task automatic send_char(input logic [7:0] c);
    int w;
    w = 0;
    while (!bus.char_ready && w < 5000) begin
      tick();
      w++;
    end
    chk("ready_wait", 32'(bus.char_ready), 32'd1);
    bus.char_in    = c;
    bus.char_valid = 1'b1;
    tick();
    bus.char_valid = 1'b0;
  endtask

  // Observe writes until char_ready rises (bounded).
  task automatic run_clear(output int ncyc, output int nwr, output int first_a,
                           output int last_a, output bit contig, output bit blank_ok,
                           output bit cur_zero);
    ncyc = 0; nwr = 0; first_a = -1; last_a = -1;
    contig = 1'b1; blank_ok = 1'b1; cur_zero = 1'b1;
    while (!bus.char_ready && ncyc < 5000) begin
      tick();
      ncyc++;
      if (bus.wr_en) begin
        if (nwr == 0) first_a = int'(bus.wr_addr);
        else if (int'(bus.wr_addr) != last_a + 1) contig = 1'b0;
        last_a = int'(bus.wr_addr);
        nwr++;
        if (bus.wr_data !== 8'h00) blank_ok = 1'b0;
      end
      if (cursor_col !== 7'd0 || cursor_row !== 6'd0) cur_zero = 1'b0;
    end
  endtask

  initial begin
    int  n, nw, fa, la;
    bit  ct, bk, cz;

    rst = 1'b1;
    bus.char_valid = 1'b0;
    bus.char_in    = 8'h00;

    // ---- reset ----
    tick();
    tick();
    chk("rst_wr_en",   32'(bus.wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk("rst_ready",   32'(bus.char_ready), 32'd0);
    chk("rst_col",     32'(cursor_col), 32'd0);
    chk("rst_row",     32'(cursor_row), 32'd0);
    chk("rst_busy",    32'(busy), 32'd1);
    rst = 1'b0;
    run_clear(n, nw, fa, la, ct, bk, cz);
    chk("init_cycles", 32'(n), 32'd2852);
    chk("init_writes", 32'(nw), 32'd2852);
    chk("init_first",  32'(fa), 32'd0);
    chk("init_last",   32'(la), 32'd2851);
    chk("init_contig", 32'(ct), 32'd1);
    chk("init_blank",  32'(bk), 32'd1);
    chk("init_busy",   32'(busy), 32'd0);
    chk("init_cursor", {25'd0, cursor_col}, 32'd0);
    tick();
    chk("idle_no_wr",  32'(bus.wr_en), 32'd0);

    // ---- printable burst "AB" back to back ----
    bus.char_in = 8'h41; bus.char_valid = 1'b1;
    tick();
    chk("A_wr_en",   32'(bus.wr_en), 32'd1);
    chk("A_addr",    32'(bus.wr_addr), 32'd0);
    chk("A_data",    32'(bus.wr_data), 32'h41);
    chk("A_ready",   32'(bus.char_ready), 32'd1);
    bus.char_in = 8'h42;
    tick();
    bus.char_valid = 1'b0;
    chk("B_wr_en",   32'(bus.wr_en), 32'd1);
    chk("B_addr",    32'(bus.wr_addr), 32'd1);
    chk("B_data",    32'(bus.wr_data), 32'h42);
    chk("AB_col",    32'(cursor_col), 32'd2);
    tick();
    chk("AB_pulse_end", 32'(bus.wr_en), 32'd0);

    // ---- line wrap ----
    for (int i = 0; i < 59; i++) send_char(8'h61);
    chk("pre_wrap_col", 32'(cursor_col), 32'd61);
    bus.char_in = 8'h58; bus.char_valid = 1'b1;
    tick();
    chk("X_wr_en", 32'(bus.wr_en), 32'd1);
    chk("X_addr",  32'(bus.wr_addr), 32'd61);
    chk("X_data",  32'(bus.wr_data), 32'h58);
    chk("X_ready", 32'(bus.char_ready), 32'd0);
    bus.char_in = 8'h5A;  // held by the source while not ready
    run_clear(n, nw, fa, la, ct, bk, cz);
    bus.char_valid = 1'b0;
    chk("wrap_writes", 32'(nw), 32'd62);
    chk("wrap_first",  32'(fa), 32'd62);
    chk("wrap_last",   32'(la), 32'd123);
    chk("wrap_contig", 32'(ct), 32'd1);
    chk("wrap_blank",  32'(bk), 32'd1);
    chk("wrap_col",    32'(cursor_col), 32'd0);
    chk("wrap_row",    32'(cursor_row), 32'd1);
    tick();
    chk("held_not_taken", 32'(bus.wr_en), 32'd0);

    // ---- bottom wrap ----
    for (int i = 0; i < 44; i++) begin
      send_char(8'h0A);
      run_clear(n, nw, fa, la, ct, bk, cz);
    end
    chk("pre_bottom_row", 32'(cursor_row), 32'd45);
    send_char(8'h0A);
    chk("lf_no_wr",    32'(bus.wr_en), 32'd0);
    chk("lf_row",      32'(cursor_row), 32'd0);
    run_clear(n, nw, fa, la, ct, bk, cz);
    chk("bot_low_cyc", 32'(n), 32'd62);
    chk("bot_writes",  32'(nw), 32'd62);
    chk("bot_first",   32'(fa), 32'd0);
    chk("bot_last",    32'(la), 32'd61);

    // ---- backspace ----
    send_char(8'h0A); run_clear(n, nw, fa, la, ct, bk, cz);
    send_char(8'h0A); run_clear(n, nw, fa, la, ct, bk, cz);
    for (int i = 0; i < 5; i++) send_char(8'h63);
    chk("c5_addr",    32'(bus.wr_addr), 32'd128);
    chk("c5_col",     32'(cursor_col), 32'd5);
    chk("c5_row",     32'(cursor_row), 32'd2);
    send_char(8'h08);
    chk("bs_wr_en",   32'(bus.wr_en), 32'd1);
    chk("bs_addr",    32'(bus.wr_addr), 32'd128);
    chk("bs_data",    32'(bus.wr_data), 32'h00);
    chk("bs_col",     32'(cursor_col), 32'd4);
    send_char(8'h7F);
    chk("drop7f_wr",  32'(bus.wr_en), 32'd0);
    chk("drop7f_col", 32'(cursor_col), 32'd4);
    send_char(8'h0D);
    chk("cr_wr",      32'(bus.wr_en), 32'd0);
    chk("cr_col",     32'(cursor_col), 32'd0);
    chk("cr_row",     32'(cursor_row), 32'd2);
    send_char(8'h08);
    chk("bs0_wr",     32'(bus.wr_en), 32'd0);
    chk("bs0_col",    32'(cursor_col), 32'd0);
    chk("bs0_row",    32'(cursor_row), 32'd2);
    chk("bs0_ready",  32'(bus.char_ready), 32'd1);

    // ---- form feed ----
    send_char(8'h31);
    send_char(8'h0C);
    chk("ff_col",     32'(cursor_col), 32'd0);
    chk("ff_row",     32'(cursor_row), 32'd0);
    chk("ff_busy",    32'(busy), 32'd1);
    run_clear(n, nw, fa, la, ct, bk, cz);
    chk("ff_cycles",  32'(n), 32'd2852);
    chk("ff_writes",  32'(nw), 32'd2852);
    chk("ff_first",   32'(fa), 32'd0);
    chk("ff_last",    32'(la), 32'd2851);
    chk("ff_contig",  32'(ct), 32'd1);
    chk("ff_cursor0", 32'(cz), 32'd1);

    // ---- reset in the middle of a full clear ----
    send_char(8'h32);
    send_char(8'h0C);
    for (int i = 0; i < 100; i++) tick();
    chk("mid_addr",   32'(bus.wr_addr), 32'd99);
    rst = 1'b1;
    tick();
    chk("mid_rst_wr", 32'(bus.wr_en), 32'd0);
    chk("mid_rst_addr", 32'(bus.wr_addr), 32'd0);
    rst = 1'b0;
    run_clear(n, nw, fa, la, ct, bk, cz);
    chk("re_writes",  32'(nw), 32'd2852);
    chk("re_first",   32'(fa), 32'd0);
    chk("re_last",    32'(la), 32'd2851);
    chk("re_col",     32'(cursor_col), 32'd0);
    chk("re_row",     32'(cursor_row), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
